// File: rtl/ntt_sched_pkg.sv
// Shared constants, twiddle table and descriptor type for the NTT schedule
// generator. The optional inverse schedule is enabled by NTT_SCHED_INV_EN.
package ntt_sched_pkg;

   localparam int N_DEFAULT       = 256;
   localparam int LOG_N_DEFAULT   = 8;
   localparam int Q               = 3329;
   localparam int ZETA_W_DEFAULT  = 12;
   localparam int LAYER_W_DEFAULT = 3;

   // zeta^brv7(k) mod Q with zeta = 17, indexed by twiddle index k
   localparam logic [11:0] ZETA_TABLE [128] = '{
      12'd1,    12'd1729, 12'd2580, 12'd3289, 12'd2642, 12'd630,  12'd1897, 12'd848,
      12'd1062, 12'd1919, 12'd193,  12'd797,  12'd2786, 12'd3260, 12'd569,  12'd1746,
      12'd296,  12'd2447, 12'd1339, 12'd1476, 12'd3046, 12'd56,   12'd2240, 12'd1333,
      12'd1426, 12'd2094, 12'd535,  12'd2882, 12'd2393, 12'd2879, 12'd1974, 12'd821,
      12'd289,  12'd331,  12'd3253, 12'd1756, 12'd1197, 12'd2304, 12'd2277, 12'd2055,
      12'd650,  12'd1977, 12'd2513, 12'd632,  12'd2865, 12'd33,   12'd1320, 12'd1915,
      12'd2319, 12'd1435, 12'd807,  12'd452,  12'd1438, 12'd2868, 12'd1534, 12'd2402,
      12'd2647, 12'd2617, 12'd1481, 12'd648,  12'd2474, 12'd3110, 12'd1227, 12'd910,
      12'd17,   12'd2761, 12'd583,  12'd2649, 12'd1637, 12'd723,  12'd2288, 12'd1100,
      12'd1409, 12'd2662, 12'd3281, 12'd233,  12'd756,  12'd2156, 12'd3015, 12'd3050,
      12'd1703, 12'd1651, 12'd2789, 12'd1789, 12'd1847, 12'd952,  12'd1461, 12'd2687,
      12'd939,  12'd2308, 12'd2437, 12'd2388, 12'd733,  12'd2337, 12'd268,  12'd641,
      12'd1584, 12'd2298, 12'd2037, 12'd3220, 12'd375,  12'd2549, 12'd2090, 12'd1645,
      12'd1063, 12'd319,  12'd2773, 12'd757,  12'd2099, 12'd561,  12'd2466, 12'd2594,
      12'd2804, 12'd1092, 12'd403,  12'd1026, 12'd1143, 12'd2150, 12'd2775, 12'd886,
      12'd1722, 12'd1212, 12'd1874, 12'd1029, 12'd2110, 12'd2935, 12'd885,  12'd2154
   };

   // One butterfly descriptor at the default geometry
   typedef struct packed {
      logic [LOG_N_DEFAULT-1:0]   addr_a;
      logic [LOG_N_DEFAULT-1:0]   addr_b;
      logic [ZETA_W_DEFAULT-1:0]  zeta;
      logic [LOG_N_DEFAULT-2:0]   zeta_idx;
      logic [LAYER_W_DEFAULT-1:0] layer;
      logic                       gs;
      logic                       last_layer_bfly;
      logic                       last;
   } ntt_desc_t;

endpackage

// File: rtl/ntt_zeta_rom.sv
// Synchronous-read twiddle ROM; dout updates only when en is high and is
// cleared by srst. Kept in registers because the table is small.
module ntt_zeta_rom
   import ntt_sched_pkg::*;
#(
   parameter int ADDR_W = LOG_N_DEFAULT - 1,
   parameter int ZETA_W = ZETA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              srst,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   output logic [ZETA_W-1:0] dout
);

   (* ram_style = "registers" *) logic [ZETA_W-1:0] dout_q;

   // Registered table lookup, held while en is low
   always_ff @(posedge clk) begin
      if (srst) begin
         dout_q <= '0;
      end else if (en) begin
         dout_q <= ZETA_W'(ZETA_TABLE[addr]);
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/ntt_sched_gen.sv
// NTT butterfly schedule generator: counters walk (layer, butterfly) and
// stream (addr_a, addr_b, zeta) descriptors through a two-stage pipeline.
// Handshake: a descriptor transfers on a rising edge where out_valid and
// out_ready are both 1; while out_valid=1 and out_ready=0 every out_* field
// holds. The Gentleman-Sande inverse ordering exists only when the macro
// NTT_SCHED_INV_EN is defined; otherwise mode is ignored.
module ntt_sched_gen
   import ntt_sched_pkg::*;
#(
   parameter int LOG_N   = LOG_N_DEFAULT,
   parameter int ZETA_W  = ZETA_W_DEFAULT,
   parameter int LAYER_W = $clog2(LOG_N - 1)
) (
   input  logic               clk,
   input  logic               srst,
   input  logic               start,
   input  logic               mode,
   output logic               busy,
   output logic               done,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LOG_N-1:0]   out_addr_a,
   output logic [LOG_N-1:0]   out_addr_b,
   output logic [ZETA_W-1:0]  out_zeta,
   output logic [LOG_N-2:0]   out_zeta_idx,
   output logic [LAYER_W-1:0] out_layer,
   output logic               out_gs,
   output logic               out_last_layer_bfly,
   output logic               out_last
);

   localparam int L  = LOG_N - 1;   // number of layers
   localparam int BW = LOG_N - 1;   // butterfly counter and twiddle index width

   // Counter stage
   logic               gen_active;
   logic [BW-1:0]      b_cnt;
   logic [LAYER_W-1:0] l_cnt;
`ifdef NTT_SCHED_INV_EN
   logic               inv_q;
   logic               s0_gs;
`else
   logic               unused_mode;
   assign unused_mode = mode;
`endif

   // S0 stage registers
   logic               s0_valid;
   logic [LOG_N-1:0]   s0_addr_a;
   logic [LOG_N-1:0]   s0_addr_b;
   logic [BW-1:0]      s0_k;
   logic [LAYER_W-1:0] s0_layer;
   logic               s0_last_lb;
   logic               s0_last;

   // Combinational descriptor for the current (b, l)
   logic [LAYER_W:0]   sh;
   logic [LOG_N-1:0]   len;
   logic [LOG_N-1:0]   g;
   logic [LOG_N-1:0]   off;
   logic [LOG_N-1:0]   addr_a_c;
   logic [LOG_N-1:0]   addr_b_c;
   logic [BW-1:0]      k_c;
   logic               last_lb_c;
   logic               last_c;
   logic [LAYER_W-1:0] l_next;

   logic adv;
   logic hs_last;

   assign adv     = !out_valid || out_ready;
   assign hs_last = out_valid && out_ready && out_last;

   // Address, twiddle index and end-of-layer/schedule flags from the counters
   always_comb begin
      sh        = (LAYER_W+1)'(L) - {1'b0, l_cnt};
      len       = LOG_N'(1) << sh;
      g         = {1'b0, b_cnt} >> sh;
      off       = {1'b0, b_cnt} & (len - LOG_N'(1));
      addr_a_c  = ((g << 1) << sh) | off;
      addr_b_c  = addr_a_c + len;
      k_c       = BW'((LOG_N'(1) << l_cnt) + g);
      last_lb_c = &b_cnt;
      last_c    = last_lb_c && (l_cnt == LAYER_W'(L - 1));
      l_next    = l_cnt + LAYER_W'(1);
`ifdef NTT_SCHED_INV_EN
      if (inv_q) begin
         k_c    = BW'((LOG_N'(2) << l_cnt) - LOG_N'(1) - g);
         last_c = last_lb_c && (l_cnt == '0);
         l_next = l_cnt - LAYER_W'(1);
      end
`endif
   end

   // Run control, counters, S0 and S1 registers, all gated by adv
   always_ff @(posedge clk) begin
      if (srst) begin
         busy                <= 1'b0;
         done                <= 1'b0;
         gen_active          <= 1'b0;
         b_cnt               <= '0;
         l_cnt               <= '0;
         s0_valid            <= 1'b0;
         s0_addr_a           <= '0;
         s0_addr_b           <= '0;
         s0_k                <= '0;
         s0_layer            <= '0;
         s0_last_lb          <= 1'b0;
         s0_last             <= 1'b0;
         out_valid           <= 1'b0;
         out_addr_a          <= '0;
         out_addr_b          <= '0;
         out_zeta_idx        <= '0;
         out_layer           <= '0;
         out_last_layer_bfly <= 1'b0;
         out_last            <= 1'b0;
`ifdef NTT_SCHED_INV_EN
         inv_q               <= 1'b0;
         s0_gs               <= 1'b0;
         out_gs              <= 1'b0;
`endif
      end else begin
         done <= hs_last;
         if (hs_last) begin
            busy <= 1'b0;
         end
         if (!busy && start) begin
            busy       <= 1'b1;
            gen_active <= 1'b1;
            b_cnt      <= '0;
`ifdef NTT_SCHED_INV_EN
            inv_q      <= mode;
            l_cnt      <= mode ? LAYER_W'(L - 1) : '0;
`else
            l_cnt      <= '0;
`endif
         end
         if (adv) begin
            if (gen_active) begin
               s0_valid   <= 1'b1;
               s0_addr_a  <= addr_a_c;
               s0_addr_b  <= addr_b_c;
               s0_k       <= k_c;
               s0_layer   <= l_cnt;
               s0_last_lb <= last_lb_c;
               s0_last    <= last_c;
`ifdef NTT_SCHED_INV_EN
               s0_gs      <= inv_q;
`endif
               if (last_c) begin
                  gen_active <= 1'b0;
               end else if (last_lb_c) begin
                  b_cnt <= '0;
                  l_cnt <= l_next;
               end else begin
                  b_cnt <= b_cnt + BW'(1);
               end
            end else begin
               s0_valid <= 1'b0;
            end
            out_valid <= s0_valid;
            if (s0_valid) begin
               out_addr_a          <= s0_addr_a;
               out_addr_b          <= s0_addr_b;
               out_zeta_idx        <= s0_k;
               out_layer           <= s0_layer;
               out_last_layer_bfly <= s0_last_lb;
               out_last            <= s0_last;
`ifdef NTT_SCHED_INV_EN
               out_gs              <= s0_gs;
`endif
            end
         end
      end
   end

`ifndef NTT_SCHED_INV_EN
   assign out_gs = 1'b0;
`endif

   // Twiddle lookup aligned with the S1 output register
   ntt_zeta_rom #(
      .ADDR_W (BW),
      .ZETA_W (ZETA_W)
   ) u_zeta_rom (
      .clk  (clk),
      .srst (srst),
      .en   (adv),
      .addr (s0_k),
      .dout (out_zeta)
   );

endmodule

// File: tb/tb_ntt_sched_gen.sv
// Self-checking bench for ntt_sched_gen: reference schedule from plain
// arithmetic, scoreboard queue, randomized backpressure and mode noise.
module tb_ntt_sched_gen;
   import ntt_sched_pkg::*;

   localparam int LOG_N   = 8;
   localparam int ZETA_W  = 12;
   localparam int LAYER_W = 3;
   localparam int HALF    = (1 << LOG_N) / 2;
   localparam int TOTAL   = (LOG_N - 1) * HALF;

   logic               clk;
   logic               srst;
   logic               start;
   logic               mode;
   logic               busy;
   logic               done;
   logic               out_valid;
   logic               out_ready;
   logic [LOG_N-1:0]   out_addr_a;
   logic [LOG_N-1:0]   out_addr_b;
   logic [ZETA_W-1:0]  out_zeta;
   logic [LOG_N-2:0]   out_zeta_idx;
   logic [LAYER_W-1:0] out_layer;
   logic               out_gs;
   logic               out_last_layer_bfly;
   logic               out_last;

   int        n_cmp  = 0;
   int        n_fail = 0;
   ntt_desc_t exp_q[$];

   ntt_sched_gen #(.LOG_N(LOG_N), .ZETA_W(ZETA_W), .LAYER_W(LAYER_W)) dut (
      .clk                 (clk),
      .srst                (srst),
      .start               (start),
      .mode                (mode),
      .busy                (busy),
      .done                (done),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_addr_a          (out_addr_a),
      .out_addr_b          (out_addr_b),
      .out_zeta            (out_zeta),
      .out_zeta_idx        (out_zeta_idx),
      .out_layer           (out_layer),
      .out_gs              (out_gs),
      .out_last_layer_bfly (out_last_layer_bfly),
      .out_last            (out_last)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic ntt_desc_t cur_desc();
      ntt_desc_t d;
      d.addr_a          = out_addr_a;
      d.addr_b          = out_addr_b;
      d.zeta            = out_zeta;
      d.zeta_idx        = out_zeta_idx;
      d.layer           = out_layer;
      d.gs              = out_gs;
      d.last_layer_bfly = out_last_layer_bfly;
      d.last            = out_last;
      return d;
   endfunction

   // Reference: descriptor number idx of a forward or inverse schedule
   function automatic ntt_desc_t ref_desc(input int idx, input bit inv);
      ntt_desc_t d;
      int lp, l, b, len, g, off, k;
      lp  = idx / HALF;
      b   = idx % HALF;
      l   = inv ? (LOG_N - 2 - lp) : lp;
      len = (1 << LOG_N) >> (l + 1);
      g   = b / len;
      off = b % len;
      k   = inv ? ((2 << l) - 1 - g) : ((1 << l) + g);
      d.addr_a          = 8'(2 * g * len + off);
      d.addr_b          = 8'(2 * g * len + off + len);
      d.zeta            = ZETA_TABLE[k];
      d.zeta_idx        = 7'(k);
      d.layer           = 3'(l);
      d.gs              = inv;
      d.last_layer_bfly = (b == HALF - 1);
      d.last            = (idx == TOTAL - 1);
      return d;
   endfunction

   task automatic spot(input string tag, input int a, input int b, input int k);
      check(tag, 64'({out_addr_a, out_addr_b, out_zeta_idx}), 64'({8'(a), 8'(b), 7'(k)}));
   endtask

   // Run one schedule; negative event indices disable that event
   task automatic run_sched(input bit mode_in, input bit rand_ready, input int bp_at,
                            input int start_at, input int rst_at);
      int        idx, cyc, bp_cnt, tail, done_cnt;
      bit        inv, hold_chk, prev_last_hs, bp_done, st_done, fin;
      ntt_desc_t held, exp_d;
`ifdef NTT_SCHED_INV_EN
      inv = mode_in;
`else
      inv = 1'b0;
`endif
      exp_q.delete();
      for (int i = 0; i < TOTAL; i++) exp_q.push_back(ref_desc(i, inv));
      idx = 0; cyc = 0; bp_cnt = 0; tail = 0; done_cnt = 0;
      hold_chk = 0; prev_last_hs = 0; bp_done = 0; st_done = 0; fin = 0;

      @(negedge clk);
      start = 1'b1; mode = mode_in; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", 64'(busy), 64'(1));
      check("start_valid0", 64'(out_valid), 64'(0));
      @(negedge clk);
      check("start_valid1", 64'(out_valid), 64'(0));

      while (!fin && cyc < 6000) begin
         @(negedge clk);
         cyc++;
         mode = 1'($urandom_range(0, 1));
         if (cyc == 1) check("latency", 64'(out_valid), 64'(1));
         if (hold_chk) check("hold", 64'({out_valid, cur_desc()}), 64'({1'b1, held}));
         hold_chk = 0;
         check("busy", 64'(busy), 64'(idx < TOTAL));
         check("done", 64'(done), 64'(prev_last_hs));
         if (done) done_cnt++;
         prev_last_hs = 0;

         if (rst_at >= 0 && idx == rst_at) begin
            srst = 1'b1;
            @(negedge clk);
            srst = 1'b0;
            check("abort_busy", 64'(busy), 64'(0));
            check("abort_valid", 64'(out_valid), 64'(0));
            for (int i = 0; i < 3; i++) begin
               check("abort_done", 64'(done), 64'(0));
               @(negedge clk);
            end
            check("abort_idle", 64'({busy, out_valid}), 64'(0));
            return;
         end

         if (start_at >= 0 && idx == start_at && !st_done) begin
            start = 1'b1; st_done = 1;
         end else begin
            start = 1'b0;
         end

         if (bp_at >= 0 && idx == bp_at && !bp_done) begin
            bp_cnt = 5; bp_done = 1;
         end
         if (bp_cnt > 0) begin
            out_ready = 1'b0; bp_cnt--;
         end else begin
            out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         end

         if (out_valid && !out_ready) begin
            held = cur_desc(); hold_chk = 1;
         end

         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("extra_beat", 64'(idx), 64'(TOTAL - 1));
            end else begin
               exp_d = exp_q.pop_front();
               check($sformatf("desc%0d", idx), 64'(cur_desc()), 64'(exp_d));
               if (!inv) begin
                  case (idx)
                     0:   spot("fwd_d0", 0, 128, 1);
                     1:   spot("fwd_d1", 1, 129, 1);
                     128: spot("fwd_d128", 0, 64, 2);
                     192: spot("fwd_d192", 128, 192, 3);
                     895: spot("fwd_last", 253, 255, 127);
                     default: ;
                  endcase
               end else begin
                  case (idx)
                     0:   spot("inv_d0", 0, 2, 127);
                     1:   spot("inv_d1", 1, 3, 127);
                     2:   spot("inv_d2", 4, 6, 126);
                     895: spot("inv_last", 127, 255, 1);
                     default: ;
                  endcase
               end
               idx++;
               prev_last_hs = (idx == TOTAL);
            end
         end

         if (idx == TOTAL) begin
            tail++;
            if (tail == 5) fin = 1;
         end
      end
      if (!fin) check("timeout", 64'(idx), 64'(TOTAL));
      check("beat_count", 64'(idx), 64'(TOTAL));
      check("done_count", 64'(done_cnt), 64'(1));
      start = 1'b0;
      out_ready = 1'b1;
   endtask

   // Directed sequence
   initial begin
      srst = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_valid", 64'(out_valid), 64'(0));
      check("rst_fields", 64'(cur_desc()), 64'(0));
      srst = 1'b0;
      @(negedge clk);

      run_sched(1'b0, 1'b0, -1, -1, -1);   // forward, ready always high
      run_sched(1'b0, 1'b0, 300, 50, -1);  // backpressure at 300, start while busy at 50
      run_sched(1'b1, 1'b1, -1, -1, -1);   // mode=1 with random ready
      run_sched(1'b0, 1'b1, -1, -1, 400);  // reset abort at descriptor 400
      run_sched(1'b0, 1'b0, -1, -1, -1);   // fresh run after abort

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
